// File: rtl/iob_gpio_arb.sv
// -----------------------------------------------------------------------------
// iob_gpio_arb
//
// Round-robin arbiter that lends one GPIO output bank to one of N_REQ
// requesting engines at a time. The owner's output/enable slice is forwarded
// to the GPIO peripheral through a registered mux. Ownership ends on an
// explicit release pulse, on the owner dropping its request, or when the
// programmable hold timeout expires. Every ownership is followed by a GAP
// cycle in which the bank is tristated before arbitration resumes.
//
// Ports:
//   clk                 system clock
//   arst_n              asynchronous reset, active-low
//   req[N_REQ]          level request per requester
//   rel[N_REQ]          release pulse per requester (owner's bit only)
//   req_out             packed per-requester output values, slice i at i*GPIO_W
//   req_oe              packed per-requester output enables, same packing
//   timeout_max         maximum hold cycles, 0 disables the timeout
//   gnt[N_REQ]          registered one-hot grant
//   owner_id            index of current owner (held after release)
//   busy                bank currently owned
//   gpio_output         to GPIO output register
//   gpio_output_enable  to GPIO output-enable register
//   timeout_evt         one-cycle pulse when ownership is revoked by timeout
// -----------------------------------------------------------------------------
module iob_gpio_arb #(
   parameter int N_REQ     = 4,
   parameter int GPIO_W    = 32,
   parameter int TIMEOUT_W = 16,
   parameter int ID_W      = 2
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        rel,
   input  logic [N_REQ*GPIO_W-1:0] req_out,
   input  logic [N_REQ*GPIO_W-1:0] req_oe,
   input  logic [TIMEOUT_W-1:0]    timeout_max,
   output logic [N_REQ-1:0]        gnt,
   output logic [ID_W-1:0]         owner_id,
   output logic                    busy,
   output logic [GPIO_W-1:0]       gpio_output,
   output logic [GPIO_W-1:0]       gpio_output_enable,
   output logic                    timeout_evt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OWN  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam logic [ID_W:0] N_REQ_V = (ID_W+1)'(N_REQ);

   // Saturating increment: the hold counter must never wrap back into the
   // timeout compare window.
   function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + TIMEOUT_W'(1);
   endfunction

   // (a + b) mod N_REQ for a, b < N_REQ.
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a,
                                                 input logic [ID_W-1:0] b);
      logic [ID_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= N_REQ_V) begin
         s = s - N_REQ_V;
      end
      return s[ID_W-1:0];
   endfunction

   logic [1:0]           state;
   logic [ID_W-1:0]      ptr;
   logic [TIMEOUT_W-1:0] hold_cnt;

   // Unpack the per-requester slices so the owner mux is a plain array index.
   logic [GPIO_W-1:0] out_arr [N_REQ];
   logic [GPIO_W-1:0] oe_arr  [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign out_arr[i] = req_out[i*GPIO_W +: GPIO_W];
      assign oe_arr[i]  = req_oe[i*GPIO_W +: GPIO_W];
   end

   // Round-robin pick: rotate the request vector so ptr lands on bit 0, take
   // the lowest set bit, then map the offset back to an absolute index.
   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic [ID_W-1:0]    sel_off;
   logic [ID_W-1:0]    sel_idx;
   logic               sel_found;

   always_comb begin
      req_dbl = {req, req};
      req_rot = req_dbl[ptr +: N_REQ];
      sel_off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            sel_off = ID_W'(k);
         end
      end
      sel_found = |req;
      sel_idx   = wrap_add(ptr, sel_off);
   end

   logic owner_rel;
   logic owner_req;
   logic tmo_hit;
   logic own_exit;

   always_comb begin
      owner_rel = rel[owner_id];
      owner_req = req[owner_id];
      tmo_hit   = (timeout_max != '0) && (hold_cnt == timeout_max - TIMEOUT_W'(1));
      own_exit  = owner_rel || !owner_req || tmo_hit;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state              <= S_IDLE;
         ptr                <= '0;
         hold_cnt           <= '0;
         gnt                <= '0;
         owner_id           <= '0;
         busy               <= 1'b0;
         gpio_output        <= '0;
         gpio_output_enable <= '0;
         timeout_evt        <= 1'b0;
      end else begin
         timeout_evt <= 1'b0;
         case (state)
            S_IDLE: begin
               if (sel_found) begin
                  state    <= S_OWN;
                  gnt      <= N_REQ'(1) << sel_idx;
                  owner_id <= sel_idx;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
               end
            end
            S_OWN: begin
               gpio_output        <= out_arr[owner_id];
               gpio_output_enable <= oe_arr[owner_id];
               hold_cnt           <= sat_inc(hold_cnt);
               if (own_exit) begin
                  // Release (explicit or implicit) takes precedence over
                  // timeout, so the event only fires when timeout acts alone.
                  state              <= S_GAP;
                  gnt                <= '0;
                  busy               <= 1'b0;
                  gpio_output        <= '0;
                  gpio_output_enable <= '0;
                  ptr                <= wrap_add(owner_id, ID_W'(1));
                  timeout_evt        <= tmo_hit && !owner_rel && owner_req;
               end
            end
            S_GAP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
